// File: rtl/riscie_pkg.sv
// Shared RISC-V core types: data width, register address width, load funct3 codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscie_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [REG_W-1:0] regAddr_t;

  // One queued load response, kept raw until it leaves the queue.
  typedef struct packed {
    regAddr_t        rd;
    logic [2:0]      funct3;
    logic [1:0]      addrLow;
    logic [XLEN-1:0] data;
  } ldEntry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result queue: FIFO of raw load responses with per-entry valid/rd visibility.
// Latency: an entry pushed at edge N is visible at the head from edge N onward (pop at N+1 earliest).
// Backpressure: push is ignored while full; pop is ignored while empty; no full bypass.
module wb_load_fifo
  import riscie_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  ldEntry_t              pushEntry,
  input  logic                  pop,
  output ldEntry_t              headEntry,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      entryValid,
  output regAddr_t [DEPTH-1:0]  entryRd
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  ldEntry_t         mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] vld;
  logic             pushAcc;
  logic             popAcc;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pushAcc    = push && !full;
  assign popAcc     = pop && !empty;
  assign headEntry  = mem[rdPtr];
  assign entryValid = vld;

  // Expose each slot's destination so the stage can build its pending mask.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entryRd[i] = mem[i].rd;
    end
  end

  // Storage carries no reset; the valid bits decide what is meaningful.
  always_ff @(posedge clk) begin
    if (pushAcc) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (pushAcc) begin
        wrPtr      <= wrPtr + 1'b1;
        vld[wrPtr] <= 1'b1;
      end
      if (popAcc) begin
        rdPtr      <= rdPtr + 1'b1;
        vld[rdPtr] <= 1'b0;
      end
      case ({pushAcc, popAcc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback merge: arbitrates ALU results and queued loads onto one register-file write port.
// Latency: ALU handshake at N -> write at N+1; load accepted at N -> write at N+2 earliest.
// Backpressure: ldReady drops when the queue is full; aluReady drops only in a forced-load cycle.
module wb_stage
  import riscie_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            aluValid,
  output logic            aluReady,
  input  logic [4:0]      aluRd,
  input  logic [31:0]     aluData,
  input  logic            ldValid,
  output logic            ldReady,
  input  logic [4:0]      ldRd,
  input  logic [2:0]      ldFunct3,
  input  logic [1:0]      ldAddrLow,
  input  logic [31:0]     ldData,
  output logic [4:0]      writeReg,
  output logic            writeEnable,
  output logic [31:0]     writeData,
  output logic [31:0]     pendingMask
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  ldEntry_t              pushEntry;
  ldEntry_t              head;
  logic                  qFull;
  logic                  qEmpty;
  logic [DEPTH-1:0]      entryValid;
  regAddr_t [DEPTH-1:0]  entryRd;
  logic [SW-1:0]         starveCnt;
  logic                  forceLd;
  logic                  aluWin;
  logic                  ldWin;
  logic [XLEN-1:0]       extData;
  logic [XLEN-1:0]       shWord;
  logic [7:0]            selByte;
  logic [15:0]           selHalf;

  assign pushEntry = '{rd: ldRd, funct3: ldFunct3, addrLow: ldAddrLow, data: ldData};

  wb_load_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (ldValid),
    .pushEntry  (pushEntry),
    .pop        (ldWin),
    .headEntry  (head),
    .full       (qFull),
    .empty      (qEmpty),
    .entryValid (entryValid),
    .entryRd    (entryRd)
  );

  assign ldReady  = !qFull;
  assign forceLd  = !qEmpty && (starveCnt == LIMIT);
  assign aluReady = !forceLd;
  assign aluWin   = aluValid && !forceLd;
  assign ldWin    = !qEmpty && !aluWin;

  // Registers that still owe a load result; x0 never counts as pending.
  always_comb begin
    pendingMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i]) begin
        pendingMask[entryRd[i]] = 1'b1;
      end
    end
    pendingMask[0] = 1'b0;
  end

  // Sign/zero-extend the head load; halfword offset bit 0 is ignored.
  always_comb begin
    shWord  = head.data >> {head.addrLow, 3'b000};
    selByte = shWord[7:0];
    selHalf = head.addrLow[1] ? head.data[31:16] : head.data[15:0];
    case (head.funct3)
      F3_LB:   extData = {{24{selByte[7]}}, selByte};
      F3_LBU:  extData = {24'd0, selByte};
      F3_LH:   extData = {{16{selHalf[15]}}, selHalf};
      F3_LHU:  extData = {16'd0, selHalf};
      F3_LW:   extData = head.data;
      default: extData = head.data;
    endcase
  end

  // Count ALU wins over a waiting load; any load write or an empty queue clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (qEmpty || ldWin) begin
      starveCnt <= '0;
    end else if (aluWin && (starveCnt != LIMIT)) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // Capture the winner; x0 results are consumed but never strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      writeEnable <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
    end else if (aluWin) begin
      writeEnable <= |aluRd;
      writeReg    <= aluRd;
      writeData   <= aluData;
    end else if (ldWin) begin
      writeEnable <= |head.rd;
      writeReg    <= head.rd;
      writeData   <= extData;
    end else begin
      writeEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: queue-level reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_stage;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk;
  logic        rst_n;
  logic        aluValid;
  logic        aluReady;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        ldValid;
  logic        ldReady;
  logic [4:0]  ldRd;
  logic [2:0]  ldFunct3;
  logic [1:0]  ldAddrLow;
  logic [31:0] ldData;
  logic [4:0]  writeReg;
  logic        writeEnable;
  logic [31:0] writeData;
  logic [31:0] pendingMask;

  int nCmp  = 0;
  int nFail = 0;

  wb_stage #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .aluValid    (aluValid),
    .aluReady    (aluReady),
    .aluRd       (aluRd),
    .aluData     (aluData),
    .ldValid     (ldValid),
    .ldReady     (ldReady),
    .ldRd        (ldRd),
    .ldFunct3    (ldFunct3),
    .ldAddrLow   (ldAddrLow),
    .ldData      (ldData),
    .writeReg    (writeReg),
    .writeEnable (writeEnable),
    .writeData   (writeData),
    .pendingMask (pendingMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] d;
  } mEnt_t;

  mEnt_t       mQ[$];
  int          mStarve = 0;
  logic        mWe = 1'b0;
  logic [4:0]  mWr = '0;
  logic [31:0] mWd = '0;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = (d >> (8 * int'(off))) & 32'hFF;
    h = (d >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      mQ.delete();
      mStarve = 0;
      mWe = 1'b0;
      mWr = '0;
      mWd = '0;
    end else begin
      bit    forced;
      bit    accept;
      bit    hadLoads;
      mEnt_t e;
      hadLoads = (mQ.size() > 0);
      forced   = hadLoads && (mStarve == STARVE_LIMIT);
      accept   = ldValid && (mQ.size() != DEPTH);
      if (!forced && aluValid) begin
        mWr = aluRd;
        mWd = aluData;
        mWe = (aluRd != 0);
        mStarve = hadLoads ? ((mStarve < STARVE_LIMIT) ? mStarve + 1 : mStarve) : 0;
      end else if (hadLoads) begin
        e   = mQ.pop_front();
        mWr = e.rd;
        mWd = extend(e.f3, e.off, e.d);
        mWe = (e.rd != 0);
        mStarve = 0;
      end else begin
        mWe = 1'b0;
        mStarve = 0;
      end
      if (accept) begin
        e.rd  = ldRd;
        e.f3  = ldFunct3;
        e.off = ldAddrLow;
        e.d   = ldData;
        mQ.push_back(e);
      end
    end
  end

  // Compare every output against the model once per cycle, away from the active edge.
  always @(negedge clk) begin : compare
    logic [31:0] pm;
    pm = '0;
    foreach (mQ[i]) pm[mQ[i].rd] = 1'b1;
    pm[0] = 1'b0;
    check("m.aluReady", 32'(aluReady), 32'(!((mQ.size() > 0) && (mStarve == STARVE_LIMIT))));
    check("m.ldReady", 32'(ldReady), 32'(mQ.size() != DEPTH));
    check("m.pendingMask", pendingMask, pm);
    check("m.writeEnable", 32'(writeEnable), 32'(mWe));
    check("m.writeReg", 32'(writeReg), 32'(mWr));
    check("m.writeData", writeData, mWd);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    aluValid = 1'b0;
    ldValid  = 1'b0;
  endtask

  task automatic setAlu(input logic [4:0] rd, input logic [31:0] d);
    aluValid = 1'b1;
    aluRd    = rd;
    aluData  = d;
  endtask

  task automatic setLd(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    ldValid   = 1'b1;
    ldRd      = rd;
    ldFunct3  = f3;
    ldAddrLow = off;
    ldData    = d;
  endtask

  logic [2:0]  extF3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111};
  logic [1:0]  extOff [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] extExp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    rst_n = 1'b1;
    aluValid = 1'b0; aluRd = '0; aluData = '0;
    ldValid = 1'b0; ldRd = '0; ldFunct3 = '0; ldAddrLow = '0; ldData = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst.writeEnable", 32'(writeEnable), 32'd0);
    check("rst.writeReg", 32'(writeReg), 32'd0);
    check("rst.writeData", writeData, 32'd0);
    check("rst.ldReady", 32'(ldReady), 32'd1);
    check("rst.aluReady", 32'(aluReady), 32'd1);
    check("rst.pendingMask", pendingMask, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc();

    // ALU only: result visible one cycle after handshake.
    setAlu(5'd5, 32'h1234);
    cyc();
    idle();
    check("alu.writeEnable", 32'(writeEnable), 32'd1);
    check("alu.writeReg", 32'(writeReg), 32'd5);
    check("alu.writeData", writeData, 32'h1234);
    cyc();
    check("alu.idleWe", 32'(writeEnable), 32'd0);
    check("alu.holdData", writeData, 32'h1234);

    // Load extension: accepted at N, written at N+2.
    for (int i = 0; i < 5; i++) begin
      setLd(5'd7, extF3[i], extOff[i], 32'h80FF_7F01);
      cyc();
      idle();
      check("ext.notYet", 32'(writeEnable), 32'd0);
      cyc();
      check("ext.writeEnable", 32'(writeEnable), 32'd1);
      check("ext.writeData", writeData, extExp[i]);
    end
    cyc();

    // Starvation: load waits behind 3 ALU writes, then is forced through.
    setAlu(5'd3, 32'h0000_0030);
    setLd(5'd9, 3'b010, 2'd0, 32'h0000_0999);
    cyc();
    ldValid = 1'b0;
    repeat (3) cyc();
    check("starve.aluReadyLow", 32'(aluReady), 32'd0);
    check("starve.aluWrite", 32'(writeReg), 32'd3);
    cyc();
    check("starve.loadReg", 32'(writeReg), 32'd9);
    check("starve.loadData", writeData, 32'h0999);
    check("starve.aluReadyBack", 32'(aluReady), 32'd1);
    cyc();
    check("starve.aluResume", 32'(writeReg), 32'd3);
    idle();
    cyc();

    // Full queue under continuous ALU traffic.
    setAlu(5'd1, 32'h0000_00A0);
    for (int r = 10; r < 14; r++) begin
      setLd(5'(r), 3'b010, 2'd0, 32'(r * 16));
      cyc();
    end
    check("full.ldReady", 32'(ldReady), 32'd0);
    check("full.pendingMask", pendingMask, 32'h0000_3C00);
    check("full.aluReady", 32'(aluReady), 32'd0);
    setLd(5'd14, 3'b010, 2'd0, 32'h0000_00E0);
    cyc();
    check("full.forcedReg", 32'(writeReg), 32'd10);
    check("full.ldReadyAgain", 32'(ldReady), 32'd1);
    cyc();
    check("full.refill", 32'(ldReady), 32'd0);
    check("full.mask2", pendingMask, 32'h0000_7800);
    idle();
    repeat (5) cyc();

    // Simultaneous enqueue and dequeue at a non-full level.
    setLd(5'd20, 3'b010, 2'd0, 32'h0000_0020);
    cyc();
    setLd(5'd21, 3'b010, 2'd0, 32'h0000_0021);
    cyc();
    check("sim.mask", pendingMask, 32'h0020_0000);
    check("sim.writeReg", 32'(writeReg), 32'd20);
    idle();
    cyc();
    check("sim.drainReg", 32'(writeReg), 32'd21);
    check("sim.drainMask", pendingMask, 32'd0);
    cyc();

    // x0 destinations: consumed, never written, never pending.
    setAlu(5'd0, 32'h0000_DEAD);
    setLd(5'd0, 3'b010, 2'd0, 32'h0000_BEEF);
    cyc();
    idle();
    check("x0.aluWe", 32'(writeEnable), 32'd0);
    check("x0.mask", pendingMask, 32'd0);
    cyc();
    check("x0.ldWe", 32'(writeEnable), 32'd0);
    cyc();
    check("x0.empty", 32'(ldReady), 32'd1);

    // Reset mid-operation discards queued loads.
    setAlu(5'd2, 32'h0000_0022);
    for (int r = 4; r < 7; r++) begin
      setLd(5'(r), 3'b010, 2'd0, 32'(r));
      cyc();
    end
    check("rstmid.mask", pendingMask, 32'h0000_0070);
    check("rstmid.we", 32'(writeEnable), 32'd1);
    idle();
    rst_n = 1'b0;
    #1;
    check("rstmid.weNow", 32'(writeEnable), 32'd0);
    check("rstmid.maskNow", pendingMask, 32'd0);
    check("rstmid.ldReady", 32'(ldReady), 32'd1);
    check("rstmid.data", writeData, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) cyc();
    setAlu(5'd6, 32'h0000_0066);
    cyc();
    idle();
    check("rstmid.firstWe", 32'(writeEnable), 32'd1);
    check("rstmid.firstReg", 32'(writeReg), 32'd6);
    check("rstmid.firstData", writeData, 32'h66);
    cyc();
    check("rstmid.quiet", 32'(writeEnable), 32'd0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001: Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  4  load-result queue entries, power of two, >=2
  STARVE_LIMIT  3  consecutive cycles a queued load may lose arbitration before it is forced through
REQ-002: Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  aluValid  in  1  ALU result present
  aluReady  out  1  ALU result accepted this cycle
  aluRd  in  5  ALU destination register
  aluData  in  32  ALU result
  ldValid  in  1  load response present
  ldReady  out  1  load queue can accept
  ldRd  in  5  load destination register
  ldFunct3  in  3  load type (LB/LH/LW/LBU/LHU)
  ldAddrLow  in  2  byte offset of load address
  ldData  in  32  raw aligned memory word
  writeReg  out  5  register-file write address
  writeEnable  out  1  register-file write strobe
  writeData  out  32  register-file write data
  pendingMask  out  32  one bit per register with a queued load
REQ-003: Clocking SHALL be one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004: Block SHALL merge ALU and load results onto the single register-file write port, at most one write per cycle.
REQ-005: Load accepted when ldValid && ldReady; ldReady SHALL equal (queue count != DEPTH), with no same-cycle full bypass.
REQ-006: Queue SHALL store {rd, funct3, addrLow, data} FIFO-ordered; loads always pass through the queue.
REQ-007: Arbitration each cycle: if queue non-empty and starveCnt == STARVE_LIMIT, load wins and aluReady=0; else if aluValid, ALU wins and aluReady=1; else queue head wins if non-empty.
REQ-008: When aluValid=0, aluReady SHALL be 1 except in the forced-load cycle.
REQ-009: starveCnt SHALL increment when queue non-empty and ALU wins, clear when a load is written or queue empty, saturate at STARVE_LIMIT.
REQ-010: Output registers SHALL update every cycle: winner's rd/data captured; writeEnable=1 only if a winner exists and rd != 0; x0 results consumed but never written.
REQ-011: Latency: ALU handshake at cycle N -> writeEnable at N+1; load accepted at N -> earliest writeEnable at N+2.
REQ-012: Load extension at dequeue: LB/LBU select byte ldAddrLow, sign/zero extend; LH/LHU select halfword ldAddrLow[1] (bit0 ignored), sign/zero extend; LW and undefined funct3 (011,110,111) pass the word unchanged.
REQ-013: pendingMask SHALL be the OR of one-hot(rd) over valid queue entries, bit 0 forced 0, combinational from queue state.
REQ-014: Simultaneous enqueue and dequeue SHALL keep count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-015: When no winner exists, writeReg and writeData SHALL hold their previous values, writeEnable=0.

Reset
REQ-016: rst_n low SHALL immediately clear queue pointers, count and starveCnt, and set writeEnable=0, writeReg=0, writeData=0; pendingMask=0, ldReady=1.
REQ-017: Reset mid-operation SHALL discard all queued loads without issuing writes; the first write after release follows REQ-011 timing.

Structure
REQ-018: Shared package riscie_pkg SHALL hold XLEN=32, register-address width 5, and LB/LH/LW/LBU/LHU funct3 constants.
REQ-019: Queue SHALL be a sub-module wb_load_fifo (DEPTH-parameterised, count, full/empty, per-entry valid/rd visibility for pendingMask); arbitration, extension and output registers stay in wb_stage.

Verification
REQ-020: ALU only: aluValid, aluRd=5, aluData=0x1234 at N -> writeEnable=1, writeReg=5, writeData=0x1234 at N+1.
REQ-021: Extension: ldData=0x80FF7F01; LB offset 3 -> 0xFFFFFF80; LBU offset 3 -> 0x00000080; LH offset 2 -> 0xFFFF80FF; LHU offset 0 -> 0x00007F01; funct3=111 -> 0x80FF7F01.
REQ-022: Starvation: one load queued, aluValid held high 5 cycles, STARVE_LIMIT=3 -> 3 ALU writes, then aluReady=0 for one cycle and load written, then ALU resumes.
REQ-023: Full queue: 4 loads enqueued under continuous ALU traffic -> ldReady=0 after 4th; pendingMask shows the 4 rd bits; simultaneous dequeue/enqueue keeps count=4.
REQ-024: x0: aluRd=0 and a load with ldRd=0 -> both consumed, writeEnable never 1, pendingMask bit0 always 0.
REQ-025: Reset mid-operation: 3 loads queued, rst_n pulsed low -> writeEnable=0 at once, pendingMask=0, ldReady=1, no queued load ever written.
